uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the matrix calculator's host link, the receive counterpart of the UART transmitter. Samples the `rx` line with the same 8N1 framing (1 start, 8 data LSB-first, 1 stop, no parity) and baud derivation as the transmitter. Delivers each received byte as a single-cycle valid pulse to the command/matrix-load logic. Flags stop-bit failures as framing errors.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `rx`  in  1  serial input; idle high; asynchronous to `clk`
- `rx_data`  out  8  last correctly framed byte; held until the next good frame
- `rx_valid`  out  1  one-cycle pulse when `rx_data` is updated
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit samples low
- `rx_busy`  out  1  high while a frame is in progress (any state other than IDLE)

## Operation
- Constants:
  - `BAUD_DIV = CLK_FREQ / BAUD_RATE`, integer division; 434 at defaults.
  - `HALF = BAUD_DIV / 2`; 217 at defaults.
- Baud counter is 16 bits wide.
- `rx` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rx_s`.
- A falling edge is `rx_s == 0` while the previous `rx_s == 1`. A line held low never re-triggers.
- FSM states are IDLE, START, DATA, STOP.
  - **IDLE:** on a falling edge, go to START with the counter at 0.
  - **START:** when the counter reaches HALF-1, sample the line.
    - Sampled 1: false start; return to IDLE with no output.
    - Sampled 0: clear the counter and go to DATA with the bit index at 0.
  - **DATA:** every BAUD_DIV cycles, sample the line and shift it into the MSB of the shift register (LSB arrives first). After the 8th sample, go to STOP.
  - **STOP:** after BAUD_DIV cycles, sample the line.
    - Sampled 1: load `rx_data` from the shift register and pulse `rx_valid`.
    - Sampled 0: pulse `rx_frame_err`; `rx_data` is unchanged.
    - In both cases, go to IDLE.
- After a frame error with the line still low (break), IDLE waits for a genuine high-to-low edge before starting again.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- There is no backpressure. The consumer must capture `rx_data` on `rx_valid`; it is overwritten only by the next good frame.
- Reset mid-frame aborts immediately. The partial byte is discarded with no pulse.

## Timing
- Reset values:
  - `rx_data` = 0x00
  - `rx_valid` = 0, `rx_frame_err` = 0, `rx_busy` = 0
  - FSM = IDLE; synchronizer flops = 1
- Let E be the cycle in which the edge is detected on `rx_s` (2–3 `clk` cycles after the physical `rx` edge).
- Sample point k (k=0 start, 1–8 data, 9 stop) is at cycle E + HALF + k·BAUD_DIV, i.e. mid-bit.
- `rx_valid` / `rx_frame_err` are asserted in cycle E + HALF + 9·BAUD_DIV + 1; that is E+4124 at defaults. They last exactly one cycle.
- `rx_busy` rises in cycle E+1 and falls in the same cycle the result pulse is asserted.
- The FSM is in IDLE half a bit before the stop bit ends. A following start edge is therefore accepted with no dead time, and back-to-back frames are received at full line rate.
- Baud tolerance: receiver accepts frames with ±2% rate mismatch.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** each sample point takes `rx_s` at counts mid-2, mid-1 and mid, and uses the 2-of-3 majority as the bit value. The decision is made at the same cycle as the single-sample case, so timing is unchanged. A 1-cycle glitch at a sample point is rejected.
- **Undefined:** a single sample at mid; the majority logic and the two extra sample registers are not compiled.

## Test plan
- Reset, line idle high for 1000 cycles -> all outputs 0; `rx_valid` never pulses.
- Send 0xA5 at 115200 with 8N1 -> single `rx_valid` at E+4124, `rx_data`=0xA5, `rx_frame_err`=0.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two `rx_valid` pulses 10·434 cycles apart, values 0x00 then 0xFF.
- Send 0x3C with the stop bit forced low, then hold the line low for 2000 cycles, then release -> one `rx_frame_err` pulse, no `rx_valid`, `rx_data` keeps its previous value, and no further frames start while the line is low.
- Low pulse of 100 cycles on an idle line -> no pulses, `rx_busy` returns to 0 at E+218. Then a 1-cycle low glitch at the bit-3 sample point of 0x55:
  - With `UART_RX_MAJORITY_EN`: `rx_data`=0x55.
  - Without it: `rx_data`=0x5D.
- Assert `rst_n` low during bit 4 of a frame, release it, then send 0x81 -> no pulse for the aborted frame, then `rx_data`=0x81 with one `rx_valid`.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side link bundle between the serial line / consumer and uart_rx.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (output rx, input rx_data, rx_valid, rx_frame_err, rx_busy);
  modport slave  (input rx, output rx_data, rx_valid, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and stop-bit framing check.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote over the last three rx_s samples.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  bus
);
  localparam int          BAUD_DIV_I = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST   = 16'(BAUD_DIV_I - 1);
  localparam logic [15:0] HALF_LAST  = 16'(BAUD_DIV_I / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_s, bit_val, fall;

  assign rx_s = sync_q[1];
  assign fall = ~rx_s & prev_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rx_s from one and two cycles back, so at the decision count
  // the vote covers counts mid-2, mid-1 and mid.
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rx_s};
  end
  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (bit_val) state_d = S_IDLE;
          else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {bit_val, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (bit_val) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default 50 MHz / 115200 (434 clocks per bit).
module tb_uart_rx;
  localparam int BD = 434;
  // rx driven at a negedge reaches rx_s two posedges later, so E = t0+2 and
  // the result pulse (E+4124) is seen at cycle t0+4126.
  localparam int LAT = 4126;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] vdata[$];
  int         vcyc[$];
  int         ecyc[$];
  int         both_cnt = 0;
  int         busy_hi = -1;

  uart_rx_if bus();
  uart_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      vdata.push_back(bus.rx_data);
      vcyc.push_back(cyc);
    end
    if (bus.rx_frame_err) ecyc.push_back(cyc);
    if (bus.rx_valid && bus.rx_frame_err) both_cnt++;
    if (bus.rx_busy) busy_hi = cyc;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; glitch_off inverts rx for one cycle, rst_off aborts with a reset.
  task automatic send(input logic [7:0] b, input logic stop_b, input int glitch_off,
                      input int rst_off, output int t0);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 10*BD; i++) begin
      if (i > 0) @(negedge clk);
      if (i == rst_off) begin
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n  = 1'b1;
        return;
      end
      bus.rx = fr[i/BD] ^ logic'(i == glitch_off);
    end
  endtask

  initial begin
    int t0, t1, nv, ne;
    bus.rx = 1'b1;
    idle(5);
    chk("rst_data",  int'(bus.rx_data), 0);
    chk("rst_valid", int'(bus.rx_valid), 0);
    chk("rst_ferr",  int'(bus.rx_frame_err), 0);
    chk("rst_busy",  int'(bus.rx_busy), 0);
    rst_n = 1'b1;

    idle(1000);
    chk("idle_nvalid", int'(vdata.size()), 0);
    chk("idle_busy",   busy_hi, -1);

    send(8'hA5, 1'b1, -1, -1, t0);
    idle(50);
    chk("a5_count", int'(vdata.size()), 1);
    chk("a5_data",  int'(vdata[0]), 'hA5);
    chk("a5_lat",   vcyc[0] - t0, LAT);
    chk("a5_nerr",  int'(ecyc.size()), 0);

    send(8'h00, 1'b1, -1, -1, t0);
    send(8'hFF, 1'b1, -1, -1, t1);
    idle(50);
    chk("b2b_count", int'(vdata.size()), 3);
    chk("b2b_d0",    int'(vdata[1]), 'h00);
    chk("b2b_d1",    int'(vdata[2]), 'hFF);
    chk("b2b_gap",   vcyc[2] - vcyc[1], 10*BD);

    send(8'h3C, 1'b0, -1, -1, t0);
    idle(2000);
    chk("fe_nerr",   int'(ecyc.size()), 1);
    chk("fe_lat",    ecyc[0] - t0, LAT);
    chk("fe_nvalid", int'(vdata.size()), 3);
    chk("fe_data",   int'(bus.rx_data), 'hFF);
    chk("fe_norest", busy_hi, t0 + LAT - 1);
    bus.rx = 1'b1;
    idle(500);
    chk("fe_release", busy_hi, t0 + LAT - 1);

    @(negedge clk);
    t0 = cyc;
    bus.rx = 1'b0;
    idle(100);
    bus.rx = 1'b1;
    idle(400);
    chk("fs_busyfall", busy_hi, t0 + 219);
    chk("fs_nvalid",   int'(vdata.size()), 3);
    chk("fs_nerr",     int'(ecyc.size()), 1);

    send(8'h55, 1'b1, 1953, -1, t0);
    idle(50);
    chk("gl_count", int'(vdata.size()), 4);
`ifdef UART_RX_MAJORITY_EN
    chk("gl_data", int'(vdata[3]), 'h55);
`else
    chk("gl_data", int'(vdata[3]), 'h5D);
`endif

    nv = vdata.size();
    ne = ecyc.size();
    send(8'hC3, 1'b1, -1, 2400, t0);
    idle(100);
    chk("ab_data",   int'(bus.rx_data), 0);
    chk("ab_busy",   int'(bus.rx_busy), 0);
    chk("ab_nvalid", int'(vdata.size()), nv);
    chk("ab_nerr",   int'(ecyc.size()), ne);

    send(8'h81, 1'b1, -1, -1, t0);
    idle(50);
    chk("p81_count", int'(vdata.size()), nv + 1);
    chk("p81_data",  int'(bus.rx_data), 'h81);
    chk("p81_lat",   vcyc[nv] - t0, LAT);
    chk("never_both", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
